// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the parametrised UART transceiver
//  parity_t    : line parity mode (none / even / odd)
//  tx_state_t  : transmitter frame position
//  rx_state_t  : receiver frame position, incl. BREAK wait after a framing error
//  IDX_W       : width of the per-frame bit index (longest frame is 13 bits)
//  frame_bits(): total bits per frame, start + data + optional parity + stop
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  localparam int IDX_W = 4;

  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter producing mid-bit and end-bit ticks
//  clk_sis  in  system clock
//  rst      in  asynchronous active-low reset
//  clear    in  hold the count at 0 (idle); overrides enable
//  enable   in  advance the count one step per cycle
//  mid_tick out count is at CLKS_PER_BIT/2 this cycle (receiver sample point)
//  end_tick out count is at CLKS_PER_BIT-1 this cycle (last cycle of the bit)
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_sis,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic mid_tick,
  output logic end_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_bit_timer: CLKS_PER_BIT must be at least 4");
  end

  logic [CNT_W-1:0] cnt;
  logic             run;

  assign run = enable && !clear;

  // Wraps to 0 on its own at the end of a bit, so a new bit (or a
  // back-to-back frame) starts with a fresh count without a clear cycle.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == CNT_END) cnt <= '0;
      else                cnt <= cnt + CNT_W'(1);
    end
  end

  assign mid_tick = run && (cnt == CNT_MID);
  assign end_tick = run && (cnt == CNT_END);

endmodule

// File: rtl/uart_xcvr_param.sv
// rtl/uart_xcvr_param.sv - parametrised full-duplex UART transceiver with rx holding register
//  clk_sis        in   system clock
//  rst            in   asynchronous active-low reset
//  tx_data        in   word to send, taken on tx_valid && tx_ready
//  tx_valid       in   tx_data valid
//  tx_ready       out  transmitter can take a word (idle, or last cycle of last stop bit)
//  tx             out  serial out, idle high
//  rx             in   serial in, asynchronous to clk_sis
//  rx_data        out  last received word
//  rx_valid       out  rx_data not yet consumed
//  rx_ready       in   consumer takes rx_data on rx_valid && rx_ready
//  rx_parity_err  out  parity mismatch on the word in rx_data
//  rx_frame_err   out  a stop bit was sampled 0 on the word in rx_data
//  rx_overrun     out  sticky: an unconsumed word was overwritten
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun
);

  localparam int      FRAME_BITS  = frame_bits(DATA_W, PARITY, STOP_BITS);
  localparam parity_t PAR_MODE    = parity_t'(PARITY[1:0]);
  localparam bit      HAS_PAR     = (PAR_MODE != PAR_NONE);
  localparam logic    PAR_ODD_BIT = (PAR_MODE == PAR_ODD);

  // Frame bit index: 0 = start, 1..DATA_W = data, then parity, then stop bits.
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(FRAME_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_chk_data_w
    $error("uart_xcvr_param: DATA_W must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_xcvr_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_xcvr_param: STOP_BITS must be 1 or 2");
  end

  // ---------------------------------------------------------------- TX
  tx_state_t         tx_state, tx_state_nxt;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_par;
  logic [IDX_W-1:0]  tx_idx;
  logic              tx_end;
  logic              tx_mid_unused;
  logic              tx_last;
  logic              tx_accept;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_sis  (clk_sis),
    .rst      (rst),
    .clear    (tx_state == TX_IDLE),
    .enable   (1'b1),
    .mid_tick (tx_mid_unused),
    .end_tick (tx_end)
  );

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx           = 1'b1;
    // Ready in the final cycle of the last stop bit lets the next start bit
    // follow with no idle gap.
    tx_last      = (tx_state == TX_STOP) && tx_end && (tx_idx == IDX_LAST);
    tx_ready     = (tx_state == TX_IDLE) || tx_last;
    tx_accept    = tx_valid && tx_ready;
    case (tx_state)
      TX_IDLE: begin
        if (tx_accept) tx_state_nxt = TX_START;
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_end) tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        tx = tx_shift[0];
        if (tx_end && tx_idx == IDX_DATA_LAST) tx_state_nxt = HAS_PAR ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx = tx_par;
        if (tx_end) tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (tx_last) tx_state_nxt = tx_accept ? TX_START : TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_idx   <= '0;
    end else if (tx_accept) begin
      tx_shift <= tx_data;
      tx_par   <= (^tx_data) ^ PAR_ODD_BIT;
      tx_idx   <= '0;
    end else if (tx_end) begin
      tx_idx <= tx_idx + IDX_W'(1);
      if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
    end
  end

  // ---------------------------------------------------------------- RX
  logic              rx_meta, rx_s;
  rx_state_t         rx_state, rx_state_nxt;
  logic [IDX_W-1:0]  rx_idx;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_par_bit;
  logic              rx_stop_bad;
  logic              rx_mid;
  logic              rx_end_unused;
  logic              rx_timer_clear;
  logic              rx_load;
  logic              rx_frame_bad;
  logic              rx_par_bad;
  logic              rx_take;

  // Synchroniser resets to the idle (high) line level so reset release
  // never looks like a start bit.
  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign rx_timer_clear = (rx_state == RX_IDLE) || (rx_state == RX_BREAK);

  // Counter starts at the falling edge, so every later mid_tick lands in the
  // middle of a bit without re-aligning.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_sis  (clk_sis),
    .rst      (rst),
    .clear    (rx_timer_clear),
    .enable   (!rx_timer_clear),
    .mid_tick (rx_mid),
    .end_tick (rx_end_unused)
  );

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_load      = 1'b0;
    // Includes the stop bit being sampled in this very cycle.
    rx_frame_bad = rx_stop_bad | ~rx_s;
    rx_par_bad   = HAS_PAR & ((^rx_shift) ^ rx_par_bit ^ PAR_ODD_BIT);
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (rx_mid) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_mid && rx_idx == IDX_DATA_LAST) rx_state_nxt = HAS_PAR ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (rx_mid) rx_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (rx_mid && rx_idx == IDX_LAST) begin
          rx_load      = 1'b1;
          rx_state_nxt = rx_frame_bad ? RX_BREAK : RX_IDLE;
        end
      end
      RX_BREAK: begin
        if (rx_s) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_par_bit  <= 1'b0;
      rx_stop_bad <= 1'b0;
    end else if (rx_state == RX_IDLE) begin
      rx_idx      <= '0;
      rx_stop_bad <= 1'b0;
    end else if (rx_mid) begin
      rx_idx <= rx_idx + IDX_W'(1);
      case (rx_state)
        RX_DATA:   rx_shift    <= {rx_s, rx_shift[DATA_W-1:1]};
        RX_PARITY: rx_par_bit  <= rx_s;
        RX_STOP:   rx_stop_bad <= rx_stop_bad | ~rx_s;
        default:   ;
      endcase
    end
  end

  // Holding register: a new word always wins; overrun only when the old
  // word is still pending and is not being taken in the same cycle.
  assign rx_take = rx_valid && rx_ready;

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (rx_load) begin
      rx_data       <= rx_shift;
      rx_valid      <= 1'b1;
      rx_parity_err <= rx_par_bad;
      rx_frame_err  <= rx_frame_bad;
      rx_overrun    <= rx_valid && !rx_take;
    end else if (rx_take) begin
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_xcvr_param.sv
// tb/tb_uart_xcvr_param.sv - self-checking loopback bench for uart_xcvr_param
module tb_uart_xcvr_param;

  localparam int DW    = 8;
  localparam int CPB   = 16;
  localparam int PAR   = 1;
  localparam int SB    = 1;
  localparam int FBITS = 1 + DW + 1 + SB;
  localparam int FCYC  = FBITS * CPB;

  logic clk_sis = 1'b0;
  logic rst     = 1'b0;
  always #5 clk_sis = ~clk_sis;

  logic [DW-1:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
  logic a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready, a_tx, b_tx;
  logic a_rx, b_rx, a_rx_valid, b_rx_valid, a_rx_ready, b_rx_ready;
  logic a_perr, a_ferr, a_ovr, b_perr, b_ferr, b_ovr;
  logic drv_sel, drv_line;

  assign a_rx = b_tx;
  assign b_rx = drv_sel ? drv_line : a_tx;

  uart_xcvr_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(SB)) u_a (
    .clk_sis(clk_sis), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_overrun(a_ovr)
  );

  uart_xcvr_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(SB)) u_b (
    .clk_sis(clk_sis), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx(b_tx), .rx(b_rx), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_overrun(b_ovr)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic          exp_bits[$];
  logic [DW-1:0] rx_log[$];

  always @(negedge clk_sis) begin
    if (b_rx_valid && b_rx_ready) rx_log.push_back(b_rx_data);
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sis);
    #1;
  endtask

  function automatic logic even_par(input logic [DW-1:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  task automatic push_frame(input logic [DW-1:0] w, input logic pbit, input logic stop);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(w[i]);
    exp_bits.push_back(pbit);
    exp_bits.push_back(stop);
  endtask

  task automatic run_frames(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input int n);
    int guard;
    guard = 0;
    exp_bits.delete();
    push_frame(w0, even_par(w0), 1'b1);
    if (n == 2) push_frame(w1, even_par(w1), 1'b1);
    while (!a_tx_ready && guard < 4 * FCYC) begin
      tick();
      guard++;
    end
    check("tx_ready_wait", a_tx_ready, 1);
    a_tx_data  = w0;
    a_tx_valid = 1'b1;
    tick();
    a_tx_data = w1;
    for (int c = 0; c < n * FCYC; c++) begin
      if (c == (n - 1) * FCYC) a_tx_valid = 1'b0;
      check("tx_line", a_tx, exp_bits[c / CPB]);
      check("tx_ready", a_tx_ready, (c % FCYC) == FCYC - 1);
      tick();
    end
  endtask

  task automatic drive_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drv_line = exp_bits[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic expect_rx(input logic [DW-1:0] d, input logic pe, input logic fe, input logic ov);
    check("rx_valid", b_rx_valid, 1);
    check("rx_data", b_rx_data, d);
    check("rx_parity_err", b_perr, pe);
    check("rx_frame_err", b_ferr, fe);
    check("rx_overrun", b_ovr, ov);
  endtask

  task automatic consume();
    b_rx_ready = 1'b1;
    tick();
    b_rx_ready = 1'b0;
    check("consume_valid", b_rx_valid, 0);
    check("consume_overrun", b_ovr, 0);
    check("consume_perr", b_perr, 0);
    check("consume_ferr", b_ferr, 0);
  endtask

  initial begin
    logic [DW-1:0] w, w2;
    logic          pb;

    a_tx_data = '0; a_tx_valid = 1'b0; b_tx_data = '0; b_tx_valid = 1'b0;
    a_rx_ready = 1'b1; b_rx_ready = 1'b0; drv_sel = 1'b0; drv_line = 1'b1;
    rst = 1'b0;
    repeat (3) tick();

    check("rst_tx", a_tx, 1);
    check("rst_tx_ready", a_tx_ready, 1);
    check("rst_rx_valid", b_rx_valid, 0);
    check("rst_rx_data", b_rx_data, 0);
    check("rst_perr", b_perr, 0);
    check("rst_ferr", b_ferr, 0);
    check("rst_ovr", b_ovr, 0);
    rst = 1'b1;
    repeat (2) tick();

    // single frame, fixed then random words
    run_frames(8'hA5, 8'h00, 1);
    expect_rx(8'hA5, 1'b0, 1'b0, 1'b0);
    consume();
    for (int k = 0; k < 3; k++) begin
      w = DW'($urandom);
      run_frames(w, 8'h00, 1);
      expect_rx(w, 1'b0, 1'b0, 1'b0);
      consume();
    end

    // back-to-back frames with tx_valid held
    b_rx_ready = 1'b1;
    rx_log.delete();
    run_frames(8'h00, 8'hFF, 2);
    repeat (20) tick();
    check("b2b_count", rx_log.size(), 2);
    check("b2b_word0", rx_log[0], 8'h00);
    check("b2b_word1", rx_log[1], 8'hFF);
    b_rx_ready = 1'b0;
    tick();

    // bench-driven frames with chosen parity bit
    drv_sel = 1'b1;
    drv_line = 1'b1;
    repeat (4) tick();
    exp_bits.delete();
    push_frame(8'h3C, 1'b1, 1'b1);
    drive_bits(FBITS);
    drv_line = 1'b1;
    repeat (4) tick();
    expect_rx(8'h3C, even_par(8'h3C) != 1'b1, 1'b0, 1'b0);
    consume();
    for (int k = 0; k < 2; k++) begin
      w  = DW'($urandom);
      pb = 1'($urandom);
      exp_bits.delete();
      push_frame(w, pb, 1'b1);
      drive_bits(FBITS);
      drv_line = 1'b1;
      repeat (4) tick();
      expect_rx(w, even_par(w) != pb, 1'b0, 1'b0);
      consume();
    end

    // stop bit low, line held low: frame error, then no frame until line high
    w = DW'($urandom);
    exp_bits.delete();
    push_frame(w, even_par(w), 1'b0);
    drive_bits(FBITS - 1);
    drv_line = 1'b0;
    repeat (40) tick();
    expect_rx(w, 1'b0, 1'b1, 1'b0);
    consume();
    repeat (200) tick();
    check("break_low_no_valid", b_rx_valid, 0);
    drv_line = 1'b1;
    repeat (20) tick();
    check("break_high_no_valid", b_rx_valid, 0);
    w2 = DW'($urandom);
    exp_bits.delete();
    push_frame(w2, even_par(w2), 1'b1);
    drive_bits(FBITS);
    drv_line = 1'b1;
    repeat (4) tick();
    expect_rx(w2, 1'b0, 1'b0, 1'b0);
    consume();

    // overrun: two frames with no consumer
    drv_sel = 1'b0;
    run_frames(8'h11, 8'h00, 1);
    run_frames(8'h22, 8'h00, 1);
    expect_rx(8'h22, 1'b0, 1'b0, 1'b1);
    consume();

    // short low glitch is a false start
    drv_sel = 1'b1;
    drv_line = 1'b0;
    repeat (4) tick();
    drv_line = 1'b1;
    repeat (200) tick();
    check("glitch_no_valid", b_rx_valid, 0);
    drv_sel = 1'b0;

    // reset in the middle of a data bit
    w = DW'($urandom);
    a_tx_data  = w;
    a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    repeat (60) tick();
    check("mid_frame_busy", a_tx_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("rst_async_tx", a_tx, 1);
    check("rst_async_ready", a_tx_ready, 1);
    check("rst_async_rx_valid", b_rx_valid, 0);
    check("rst_async_rx_data", b_rx_data, 0);
    tick();
    rst = 1'b1;
    repeat (300) tick();
    check("rst_no_partial_word", b_rx_valid, 0);
    check("rst_tx_idle", a_tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
